// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions; emits one predictor update per resolved branch.
// Optional BP_RESOLVE_STATS_EN adds saturating resolve and mispredict counters.
module bp_resolve_queue #(
    parameter int bht_idx_width_p = 10,
    parameter int els_p           = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    input  logic                       pred_sel_global_i,
    output logic                       pred_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       taken_o,
    output logic                       sel_global_o,
    output logic [$clog2(els_p):0]     count_o
`ifdef BP_RESOLVE_STATS_EN
    ,
    output logic [31:0]                stat_total_o,
    output logic [31:0]                stat_miss_o
`endif
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       taken;
        logic                       sel_global;
    } entry_t;

    entry_t             mem [els_p];
    entry_t             head;
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;
    logic               enq;
    logic               deq;

    // Ready comes from the registered count only, so a same-cycle dequeue never frees a slot.
    assign pred_ready_o = (count != cnt_w'(els_p));
    assign count_o      = count;
    assign enq          = pred_v_i & pred_ready_o & ~flush_i;
    assign deq          = res_v_i & (count != '0);
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
            if (deq) rd_ptr <= rd_ptr + ptr_w'(1);
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked by count and pointers alone.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= '{idx: pred_idx_i, taken: pred_taken_i, sel_global: pred_sel_global_i};
    end

    // Update fields hold their last value between dequeues.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            w_v_o        <= 1'b0;
            idx_w_o      <= '0;
            correct_o    <= 1'b0;
            taken_o      <= 1'b0;
            sel_global_o <= 1'b0;
        end else begin
            w_v_o <= deq;
            if (deq) begin
                idx_w_o      <= head.idx;
                correct_o    <= (head.taken == res_taken_i);
                taken_o      <= res_taken_i;
                sel_global_o <= head.sel_global;
            end
        end
    end

`ifdef BP_RESOLVE_STATS_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stat_total_o <= '0;
            stat_miss_o  <= '0;
        end else if (deq) begin
            if (stat_total_o != '1) stat_total_o <= stat_total_o + 32'd1;
            if ((head.taken != res_taken_i) && (stat_miss_o != '1)) stat_miss_o <= stat_miss_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed self-checking bench for bp_resolve_queue: vector table plus hand-written corner sequences.
module tb_bp_resolve_queue;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       pred_v_i, pred_taken_i, pred_sel_global_i;
    logic [9:0] pred_idx_i;
    logic       pred_ready_o;
    logic       res_v_i, res_taken_i, flush_i;
    logic       w_v_o, correct_o, taken_o, sel_global_o;
    logic [9:0] idx_w_o;
    logic [3:0] count_o;
`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_total_o, stat_miss_o;
`endif

    int checks   = 0;
    int failures = 0;

    bp_resolve_queue #(.bht_idx_width_p(10), .els_p(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_sel_global_i(pred_sel_global_i), .pred_ready_o(pred_ready_o),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
        .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o), .taken_o(taken_o),
        .sel_global_o(sel_global_o), .count_o(count_o)
`ifdef BP_RESOLVE_STATS_EN
        , .stat_total_o(stat_total_o), .stat_miss_o(stat_miss_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       pv;
        logic [9:0] pidx;
        logic       pt, ps, rv, rt, fl;
        logic       ew;
        logic [9:0] eidx;
        logic       ec, et, es;
        logic [3:0] ecnt;
        logic       erdy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then idle the inputs; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic pv, input logic [9:0] pidx, input logic pt, input logic ps,
                         input logic rv, input logic rt, input logic fl);
        pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = pt; pred_sel_global_i = ps;
        res_v_i = rv; res_taken_i = rt; flush_i = fl;
        @(posedge clk_i);
        #1;
        pred_v_i = 1'b0; res_v_i = 1'b0; flush_i = 1'b0;
        pred_idx_i = '0; pred_taken_i = 1'b0; pred_sel_global_i = 1'b0; res_taken_i = 1'b0;
    endtask

    logic [9:0] exp_q[$];
    logic [9:0] e;

    initial begin
        pred_v_i = 0; pred_idx_i = 0; pred_taken_i = 0; pred_sel_global_i = 0;
        res_v_i = 0; res_taken_i = 0; flush_i = 0;
        reset_i = 1'b0;

        //          pv  pidx    pt ps rv rt fl | ew eidx    ec et es cnt rdy
        vecs[0] = '{1, 10'h005, 1, 1, 0, 0, 0,   0, 10'h000, 0, 0, 0, 4'd1, 1};
        vecs[1] = '{0, 10'h000, 0, 0, 1, 0, 0,   1, 10'h005, 0, 0, 1, 4'd0, 1};
        vecs[2] = '{0, 10'h000, 0, 0, 1, 1, 0,   0, 10'h005, 0, 0, 1, 4'd0, 1};
        vecs[3] = '{1, 10'h0a3, 0, 0, 1, 1, 0,   0, 10'h005, 0, 0, 1, 4'd1, 1};
        vecs[4] = '{0, 10'h000, 0, 0, 1, 0, 0,   1, 10'h0a3, 1, 0, 0, 4'd0, 1};
        vecs[5] = '{0, 10'h000, 0, 0, 0, 0, 0,   0, 10'h0a3, 1, 0, 0, 4'd0, 1};

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_count", 32'(count_o), 0);
        check("reset_ready", 32'(pred_ready_o), 1);
        check("reset_w_v", 32'(w_v_o), 0);
        check("reset_idx_w", 32'(idx_w_o), 0);
        check("reset_correct", 32'(correct_o), 0);
        check("reset_taken", 32'(taken_o), 0);
        check("reset_sel", 32'(sel_global_o), 0);
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].pv, vecs[i].pidx, vecs[i].pt, vecs[i].ps, vecs[i].rv, vecs[i].rt, vecs[i].fl);
            check($sformatf("vec%0d_w_v", i), 32'(w_v_o), 32'(vecs[i].ew));
            check($sformatf("vec%0d_idx_w", i), 32'(idx_w_o), 32'(vecs[i].eidx));
            check($sformatf("vec%0d_correct", i), 32'(correct_o), 32'(vecs[i].ec));
            check($sformatf("vec%0d_taken", i), 32'(taken_o), 32'(vecs[i].et));
            check($sformatf("vec%0d_sel", i), 32'(sel_global_o), 32'(vecs[i].es));
            check($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_ready", i), 32'(pred_ready_o), 32'(vecs[i].erdy));
        end

        // Fill to capacity, try a ninth enqueue, then drain in order.
        for (int i = 0; i < 8; i++) begin
            logic [9:0] fi;
            fi = 10'(i * 3 + 1);
            cycle(1, fi, fi[0], fi[1], 0, 0, 0);
        end
        check("full_count", 32'(count_o), 8);
        check("full_ready", 32'(pred_ready_o), 0);
        cycle(1, 10'h3ff, 0, 0, 0, 0, 0);
        check("drop_count", 32'(count_o), 8);
        for (int i = 0; i < 8; i++) begin
            logic [9:0] fi;
            fi = 10'(i * 3 + 1);
            cycle(0, 0, 0, 0, 1, 1, 0);
            check($sformatf("drain%0d_w_v", i), 32'(w_v_o), 1);
            check($sformatf("drain%0d_idx", i), 32'(idx_w_o), 32'(fi));
            check($sformatf("drain%0d_correct", i), 32'(correct_o), 32'(fi[0]));
            check($sformatf("drain%0d_sel", i), 32'(sel_global_o), 32'(fi[1]));
        end
        check("drain_count", 32'(count_o), 0);
        check("drain_ready", 32'(pred_ready_o), 1);

        // Steady state at depth 3 with pointer wrap.
        for (int n = 0; n < 3; n++) begin
            e = 10'(10'h200 + n);
            exp_q.push_back(e);
            cycle(1, e, e[0], e[1], 0, 0, 0);
        end
        check("wrap_pre_count", 32'(count_o), 3);
        for (int n = 3; n < 23; n++) begin
            logic [9:0] h;
            e = 10'(10'h200 + n);
            h = exp_q.pop_front();
            exp_q.push_back(e);
            cycle(1, e, e[0], e[1], 1, 1, 0);
            check($sformatf("wrap%0d_w_v", n), 32'(w_v_o), 1);
            check($sformatf("wrap%0d_idx", n), 32'(idx_w_o), 32'(h));
            check($sformatf("wrap%0d_correct", n), 32'(correct_o), 32'(h[0]));
            check($sformatf("wrap%0d_count", n), 32'(count_o), 3);
        end
        while (exp_q.size() > 0) begin
            logic [9:0] h;
            h = exp_q.pop_front();
            cycle(0, 0, 0, 0, 1, 0, 0);
            check("wrap_tail_idx", 32'(idx_w_o), 32'(h));
            check("wrap_tail_correct", 32'(correct_o), 32'(!h[0]));
        end
        check("wrap_end_count", 32'(count_o), 0);

        // Flush with a same-cycle resolve and prediction at depth 4.
        for (int i = 0; i < 4; i++) cycle(1, 10'(10'h100 + i), 0, 0, 0, 0, 0);
        check("flush_pre_count", 32'(count_o), 4);
        cycle(1, 10'h3ff, 1, 1, 1, 0, 1);
        check("flush_w_v", 32'(w_v_o), 1);
        check("flush_idx", 32'(idx_w_o), 32'h100);
        check("flush_correct", 32'(correct_o), 1);
        check("flush_count", 32'(count_o), 0);
        check("flush_ready", 32'(pred_ready_o), 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("flush_after_w_v", 32'(w_v_o), 0);
        check("flush_after_count", 32'(count_o), 0);
        cycle(1, 10'h055, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        check("post_flush_idx", 32'(idx_w_o), 32'h055);
        check("post_flush_correct", 32'(correct_o), 1);
        check("post_flush_count", 32'(count_o), 0);

        // Reset asserted between edges with five entries queued.
        for (int i = 0; i < 5; i++) cycle(1, 10'(10'h010 + i), 1, 1, 0, 0, 0);
        check("prereset_count", 32'(count_o), 5);
        reset_i = 1'b0;
        #1;
        check("midreset_count", 32'(count_o), 0);
        check("midreset_ready", 32'(pred_ready_o), 1);
        check("midreset_w_v", 32'(w_v_o), 0);
        check("midreset_idx_w", 32'(idx_w_o), 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("postreset_empty_w_v", 32'(w_v_o), 0);

`ifdef BP_RESOLVE_STATS_EN
        check("stat_total_reset", stat_total_o, 0);
        check("stat_miss_reset", stat_miss_o, 0);
        for (int i = 0; i < 6; i++) cycle(1, 10'(10'h020 + i), 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, (i != 1 && i != 4), 0);
        check("stat_total", stat_total_o, 6);
        check("stat_miss", stat_miss_o, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
